// File: rtl/cla_pipe_nb.sv
// Pipelined carry-lookahead adder/subtractor: one CHUNK-bit slice per stage,
// registered carry between stages, valid/ready handshake with global stall.
module cla_pipe_nb #(
  parameter int N     = 64,
  parameter int CHUNK = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned S   = N / CHUNK;
  localparam int unsigned GRP = CHUNK / 4;

  // Returns {carry out, carry into MSB, sum}; group carries are expanded as
  // flat sum-of-products over group G/P, so no ripple between 4-bit groups.
  function automatic logic [CHUNK+1:0] slice_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
    logic [CHUNK-1:0] g, p;
    logic [GRP-1:0]   gg, gp;
    logic [GRP:0]     gc;
    logic [CHUNK:0]   c;
    logic             t;
    int unsigned      bs;
    g = x & y;
    p = x ^ y;
    for (int unsigned j = 0; j < GRP; j++) begin
      bs    = 4 * j;
      gg[j] = g[bs+3] | (p[bs+3] & g[bs+2]) | (p[bs+3] & p[bs+2] & g[bs+1]) |
              (p[bs+3] & p[bs+2] & p[bs+1] & g[bs]);
      gp[j] = &p[bs +: 4];
    end
    gc    = '0;
    gc[0] = ci;
    for (int unsigned j = 0; j < GRP; j++) begin
      t = ci;
      for (int unsigned i = 0; i <= j; i++) t = t & gp[i];
      gc[j+1] = t;
      for (int unsigned i = 0; i <= j; i++) begin
        t = gg[i];
        for (int unsigned m = i + 1; m <= j; m++) t = t & gp[m];
        gc[j+1] = gc[j+1] | t;
      end
    end
    c = '0;
    for (int unsigned j = 0; j < GRP; j++) begin
      bs       = 4 * j;
      c[bs]    = gc[j];
      c[bs+1]  = g[bs] | (p[bs] & gc[j]);
      c[bs+2]  = g[bs+1] | (p[bs+1] & g[bs]) | (p[bs+1] & p[bs] & gc[j]);
      c[bs+3]  = g[bs+2] | (p[bs+2] & g[bs+1]) | (p[bs+2] & p[bs+1] & g[bs]) |
                 (p[bs+2] & p[bs+1] & p[bs] & gc[j]);
    end
    c[CHUNK] = gc[GRP];
    return {c[CHUNK], c[CHUNK-1], p ^ c[CHUNK-1:0]};
  endfunction

  logic             valid_q [S];
  logic             valid_d [S];
  logic [N-1:0]     opa_q   [S];
  logic [N-1:0]     opa_d   [S];
  logic [N-1:0]     opb_q   [S];
  logic [N-1:0]     opb_d   [S];
  logic [N-1:0]     sum_q   [S];
  logic [N-1:0]     sum_d   [S];
  logic             cy_q    [S];
  logic             cy_d    [S];
  logic             zero_q  [S];
  logic             zero_d  [S];
  logic [CHUNK+1:0] res     [S];
  logic             ovf_q, ovf_d;
  logic             advance;

  assign advance  = !valid_q[S-1] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < S; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign valid_d[0] = in_valid;
      assign opa_d[0]   = a;
      assign opb_d[0]   = sub ? ~b : b;
      assign res[0]     = slice_add(a[CHUNK-1:0], opb_d[0][CHUNK-1:0], sub | c_in);
      assign sum_d[0]   = N'(res[0][CHUNK-1:0]);
      assign zero_d[0]  = ~|res[0][CHUNK-1:0];
    end else begin : g_next
      assign valid_d[k] = valid_q[k-1];
      assign opa_d[k]   = opa_q[k-1];
      assign opb_d[k]   = opb_q[k-1];
      assign res[k]     = slice_add(opa_q[k-1][k*CHUNK +: CHUNK],
                                    opb_q[k-1][k*CHUNK +: CHUNK], cy_q[k-1]);
      // Upper slices of an in-flight sum are always zero, so OR-ing in place is safe.
      assign sum_d[k]   = sum_q[k-1] | (N'(res[k][CHUNK-1:0]) << (k * CHUNK));
      assign zero_d[k]  = zero_q[k-1] & ~|res[k][CHUNK-1:0];
    end
    assign cy_d[k] = res[k][CHUNK+1];
  end

  assign ovf_d = res[S-1][CHUNK+1] ^ res[S-1][CHUNK];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < S; i++) begin
        valid_q[i] <= 1'b0;
        opa_q[i]   <= '0;
        opb_q[i]   <= '0;
        sum_q[i]   <= '0;
        cy_q[i]    <= 1'b0;
        zero_q[i]  <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int unsigned i = 0; i < S; i++) begin
        valid_q[i] <= valid_d[i];
        opa_q[i]   <= opa_d[i];
        opb_q[i]   <= opb_d[i];
        sum_q[i]   <= sum_d[i];
        cy_q[i]    <= cy_d[i];
        zero_q[i]  <= zero_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = valid_q[S-1];
  assign sum       = sum_q[S-1];
  assign c_out     = cy_q[S-1];
  assign zero      = zero_q[S-1];
  assign ovf       = ovf_q;

endmodule
